// File: rtl/time_display_if.sv
// Signal bundle between the timekeeping core and the 6-digit multiplexed display driver.
interface time_display_if;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       buzzer;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_done;

    modport master (
        output hours, mins, secs, buzzer,
        input  an, seg, dp, conv_done
    );

    modport slave (
        input  hours, mins, secs, buzzer,
        output an, seg, dp, conv_done
    );
endinterface

// File: rtl/time_display_mux.sv
// HH.MM.SS multiplexed 7-segment driver: per-frame sequential binary-to-BCD
// conversion, digit scanning and buzzer-driven blinking.
module time_display_mux #(
    parameter int unsigned DIGIT_TICKS  = 125000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input logic          clk,
    input logic          reset,
    time_display_if.slave io
);
    localparam int unsigned TICK_W  = $clog2(DIGIT_TICKS);
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SUB, COMMIT} conv_state_t;

    logic [TICK_W-1:0]  tick_cnt;
    logic [2:0]         digit_idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;
    logic               frame_start;

    conv_state_t state;
    logic [2:0]  sub_cnt;
    logic [4:0]  work_h;
    logic [5:0]  work_m;
    logic [5:0]  work_s;
    logic [1:0]  tens_h;
    logic [2:0]  tens_m;
    logic [2:0]  tens_s;

    logic [1:0]  disp_h_tens;
    logic [3:0]  disp_h_ones;
    logic [2:0]  disp_m_tens;
    logic [3:0]  disp_m_ones;
    logic [2:0]  disp_s_tens;
    logic [3:0]  disp_s_ones;

    logic [3:0]  cur_bcd;
    logic [5:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        conv_done_q;

    assign frame_start  = (tick_cnt == '0) && (digit_idx == '0);
    assign io.an        = an_q;
    assign io.seg       = seg_q;
    assign io.dp        = dp_q;
    assign io.conv_done = conv_done_q;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!io.buzzer) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Six repeated-subtraction steps cover the largest field value (63).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sub_cnt     <= '0;
            work_h      <= '0;
            work_m      <= '0;
            work_s      <= '0;
            tens_h      <= '0;
            tens_m      <= '0;
            tens_s      <= '0;
            disp_h_tens <= '0;
            disp_h_ones <= '0;
            disp_m_tens <= '0;
            disp_m_ones <= '0;
            disp_s_tens <= '0;
            disp_s_ones <= '0;
            conv_done_q <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) state <= LOAD;
                end
                LOAD: begin
                    work_h  <= io.hours;
                    work_m  <= io.mins;
                    work_s  <= io.secs;
                    tens_h  <= '0;
                    tens_m  <= '0;
                    tens_s  <= '0;
                    sub_cnt <= '0;
                    state   <= SUB;
                end
                SUB: begin
                    if (work_h >= 5'd10) begin
                        work_h <= work_h - 5'd10;
                        tens_h <= tens_h + 2'd1;
                    end
                    if (work_m >= 6'd10) begin
                        work_m <= work_m - 6'd10;
                        tens_m <= tens_m + 3'd1;
                    end
                    if (work_s >= 6'd10) begin
                        work_s <= work_s - 6'd10;
                        tens_s <= tens_s + 3'd1;
                    end
                    if (sub_cnt == 3'd5) begin
                        state       <= COMMIT;
                        conv_done_q <= 1'b1;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                COMMIT: begin
                    disp_h_tens <= tens_h;
                    disp_h_ones <= work_h[3:0];
                    disp_m_tens <= tens_m;
                    disp_m_ones <= work_m[3:0];
                    disp_s_tens <= tens_s;
                    disp_s_ones <= work_s[3:0];
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur_bcd = '0;
        case (digit_idx)
            3'd0:    cur_bcd = disp_s_ones;
            3'd1:    cur_bcd = {1'b0, disp_s_tens};
            3'd2:    cur_bcd = disp_m_ones;
            3'd3:    cur_bcd = {1'b0, disp_m_tens};
            3'd4:    cur_bcd = disp_h_ones;
            3'd5:    cur_bcd = {2'b00, disp_h_tens};
            default: cur_bcd = '0;
        endcase
    end

    // Blanking is gated with the live buzzer so a falling buzzer re-enables
    // the digits on the very next registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= '1;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= (blink_phase && io.buzzer) ? 6'h3F : ~(6'd1 << digit_idx);
            seg_q <= seg_of(cur_bcd);
            dp_q  <= !((digit_idx == 3'd2) || (digit_idx == 3'd4));
        end
    end
endmodule
